logic_unit_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one gate-level, delay-annotated bitwise AND unit among N requesters. It latches the winner's operands onto the shared unit and waits a fixed number of settle cycles for the gate delays to resolve. It then captures the result and returns it with a one-cycle completion pulse. It sits between the lab's requester blocks and the single delayed AND datapath instance.

---
 rtl/logic_unit_arbiter.sv | 171 +++++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: shares one delayed bitwise-AND unit among N requesters.
// A winner is picked in IDLE, its operands are launched onto the shared unit,
// the block waits SETTLE cycles for the gates to resolve, captures unit_y
// and returns it with a one-cycle done pulse to the winner.
//
// Build option: define LOGIC_ARB_RR_EN for round-robin arbitration with a
// rotating pointer; leave it undefined for fixed priority (lowest index wins).
//
// Handshake: req is a level request. A grant is registered on the edge where
// req is seen in IDLE. gnt/busy stay high for the whole transaction. done is
// a one-hot pulse lasting exactly one cycle, starting on the capture edge
// (the edge where gnt/busy drop). The requester may drop req at any time
// after the grant; the transaction still completes.
module logic_unit_arbiter #(
  parameter int N      = 4,
  parameter int W      = 8,
  parameter int SETTLE = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_flat,
  input  logic [N*W-1:0] b_flat,
  input  logic [W-1:0]   unit_y,
  output logic [W-1:0]   unit_a,
  output logic [W-1:0]   unit_b,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic [W-1:0]   result,
  output logic           busy,
  output logic           state_dbg
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          launch;
  logic          capture;

  // Arbitration results
  logic [N-1:0]  search_vec;
  logic [PW-1:0] search_off;
  logic [PW-1:0] pick_idx;
  logic [N-1:0]  pick_oh;
  logic [W-1:0]  pick_a;
  logic [W-1:0]  pick_b;

  assign state_dbg = (state_q == S_WAIT);

`ifdef LOGIC_ARB_RR_EN
  logic [PW-1:0] ptr_q;
  logic [PW:0]   rr_sum;

  // Rotate requests so the pointer position becomes bit 0 of the search.
  assign search_vec = N'({req, req} >> ptr_q);

  // Map the offset found in the rotated vector back to a requester index.
  always_comb begin
    rr_sum = {1'b0, ptr_q} + {1'b0, search_off};
    if (rr_sum >= (PW+1)'(N)) begin
      rr_sum = rr_sum - (PW+1)'(N);
    end
    pick_idx = rr_sum[PW-1:0];
  end

  // Pointer moves to winner+1 (mod N) at every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (launch) begin
      ptr_q <= (pick_idx == PW'(N - 1)) ? '0 : pick_idx + PW'(1);
    end
  end
`else
  // Fixed priority: search starts at requester 0 every time.
  assign search_vec = req;
  assign pick_idx   = search_off;
`endif

  // Lowest set bit of the search vector; scanning downward so the last hit wins.
  always_comb begin
    search_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (search_vec[i]) begin
        search_off = PW'(i);
      end
    end
  end

  // Winner one-hot and operand mux.
  always_comb begin
    pick_oh = {{(N-1){1'b0}}, 1'b1} << pick_idx;
    pick_a  = '0;
    pick_b  = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_idx == PW'(i)) begin
        pick_a = a_flat[i*W +: W];
        pick_b = b_flat[i*W +: W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic with launch/capture strobes.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          launch  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: launch operands at grant, count settle cycles, capture result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt    <= '0;
      done   <= '0;
      unit_a <= '0;
      unit_b <= '0;
      result <= '0;
      busy   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done <= '0;
      if (launch) begin
        gnt    <= pick_oh;
        unit_a <= pick_a;
        unit_b <= pick_b;
        cnt_q  <= CNT_LOAD;
        busy   <= 1'b1;
      end else if (capture) begin
        result <= unit_y;
        done   <= gnt;
        gnt    <= '0;
        busy   <= 1'b0;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Testbench for logic_unit_arbiter: directed scenarios then random traffic,
// compared every cycle against a transaction-level reference model.
module tb_logic_unit_arbiter;

  localparam int N      = 4;
  localparam int W      = 8;
  localparam int SETTLE = 2;
  localparam int TCLK   = 10;

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] a_flat = '0;
  logic [N*W-1:0] b_flat = '0;
  logic [W-1:0]   unit_y;
  logic [W-1:0]   unit_a;
  logic [W-1:0]   unit_b;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [W-1:0]   result;
  logic           busy;
  logic           state_dbg;

  always #(TCLK/2) clk = ~clk;

  // Shared AND unit with a gate delay that resolves just before the capture edge.
  assign #(SETTLE*TCLK - 3) unit_y = unit_a & unit_b;

  logic_unit_arbiter #(.N(N), .W(W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .unit_y(unit_y), .unit_a(unit_a), .unit_b(unit_b), .gnt(gnt),
    .done(done), .result(result), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- reference model / scoreboard ----------------
  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  bit           m_busy;
  int           m_cap;
  int           m_ptr;
  logic [N-1:0] m_gnt, m_done;
  logic [W-1:0] m_a, m_b, m_res;
  logic [W-1:0] exp_q[$];
  int           dut_log[$];
  logic [N-1:0] prev_gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int arbitrate(input logic [N-1:0] r);
    int win = 0;
`ifdef LOGIC_ARB_RR_EN
    for (int k = N - 1; k >= 0; k--) if (r[(m_ptr + k) % N]) win = (m_ptr + k) % N;
`else
    for (int k = N - 1; k >= 0; k--) if (r[k]) win = k;
`endif
    return win;
  endfunction

  function automatic int oh_index(input logic [N-1:0] v);
    int idx = -1;
    for (int i = 0; i < N; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_cap = 0; m_ptr = 0;
    m_gnt = '0; m_done = '0; m_a = '0; m_b = '0; m_res = '0;
    exp_q.delete();
    prev_gnt = '0;
  endtask

  task automatic check_all();
    chk("gnt", 32'(gnt), 32'(m_gnt));
    chk("done", 32'(done), 32'(m_done));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("unit_a", 32'(unit_a), 32'(m_a));
    chk("unit_b", 32'(unit_b), 32'(m_b));
    chk("result", 32'(result), 32'(m_res));
  endtask

  // ---------------- driver: one clock step with model update ----------------
  task automatic step();
    int win;
    m_done = '0;
    if (rst_n) begin
      if (m_busy) begin
        if (cyc == m_cap) begin
          m_res  = exp_q.pop_front();
          m_done = m_gnt;
          m_gnt  = '0;
          m_busy = 0;
        end
      end else if (req != '0) begin
        win    = arbitrate(req);
        m_gnt  = '0;
        m_gnt[win] = 1'b1;
        m_a    = a_flat[win*W +: W];
        m_b    = b_flat[win*W +: W];
        exp_q.push_back(m_a & m_b);
        m_busy = 1;
        m_cap  = cyc + SETTLE;
        m_ptr  = (win + 1) % N;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    check_all();
    if (gnt != '0 && prev_gnt == '0) dut_log.push_back(oh_index(gnt));
    prev_gnt = gnt;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    #2;
    check_all();              // reset state before any edge
    do_reset();

    // Single request from requester 1.
    a_flat[1*W +: W] = 8'hF0;
    b_flat[1*W +: W] = 8'h3C;
    req = 4'b0010;
    step();
    chk("t1_gnt", 32'(gnt), 32'h2);
    chk("t1_unit_a", 32'(unit_a), 32'hF0);
    chk("t1_unit_b", 32'(unit_b), 32'h3C);
    req = 4'b0000;
    a_flat[1*W +: W] = 8'h00;  // operand change during WAIT must be ignored
    step();
    step();
    chk("t1_result", 32'(result), 32'h30);
    chk("t1_done", 32'(done), 32'h2);
    chk("t1_gnt_drop", 32'(gnt), 32'h0);
    step();
    chk("t1_done_pulse", 32'(done), 32'h0);
    chk("t1_result_hold", 32'(result), 32'h30);

    // All requesters held: grant order from a fresh pointer.
    do_reset();
    for (int i = 0; i < N; i++) begin
      a_flat[i*W +: W] = 8'(8'h11 * (i + 1));
      b_flat[i*W +: W] = 8'hFF;
    end
    dut_log.delete();
    req = 4'b1111;
    for (int s = 0; s < 5 * (SETTLE + 1); s++) step();
    chk("t2_count", 32'(dut_log.size()), 32'd5);
    if (dut_log.size() >= 5) begin
`ifdef LOGIC_ARB_RR_EN
      chk("t2_order0", 32'(dut_log[0]), 32'd0);
      chk("t2_order1", 32'(dut_log[1]), 32'd1);
      chk("t2_order2", 32'(dut_log[2]), 32'd2);
      chk("t2_order3", 32'(dut_log[3]), 32'd3);
      chk("t2_order4", 32'(dut_log[4]), 32'd0);
`else
      for (int i = 0; i < 5; i++) chk("t2_fixed", 32'(dut_log[i]), 32'd0);
`endif
    end

    // Requesters 1 and 3 held.
    req = 4'b0000;
    for (int s = 0; s < SETTLE + 1; s++) step();
    dut_log.delete();
    req = 4'b1010;
    for (int s = 0; s < 4 * (SETTLE + 1); s++) step();
    chk("t3_count", 32'(dut_log.size()), 32'd4);
    for (int i = 0; i < dut_log.size(); i++) begin
`ifdef LOGIC_ARB_RR_EN
      chk("t3_alt", 32'(dut_log[i]), (i % 2 == 0) ? 32'd1 : 32'd3);
`else
      chk("t3_fixed", 32'(dut_log[i]), 32'd1);
`endif
    end

    // Request withdrawn during WAIT: done still pulses, next grant goes elsewhere.
    req = 4'b0000;
    for (int s = 0; s < SETTLE + 1; s++) step();
    dut_log.delete();
    req = 4'b0010;
    step();
    req = 4'b0000;
    for (int s = 0; s < SETTLE - 1; s++) step();
    req = 4'b1000;
    step();
    chk("t4_done", 32'(done), 32'h2);
    step();
    chk("t4_next", 32'(gnt), 32'h8);
    for (int s = 0; s < SETTLE; s++) step();
    req = 4'b0000;
    step();

    // Reset while the settle counter is 1.
    req = 4'b0100;
    step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_gnt", 32'(gnt), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_unit_a", 32'(unit_a), 32'h0);
    chk("t5_result", 32'(result), 32'h0);
    step();
    rst_n = 1'b1;
    req = 4'b1111;
    step();
    chk("t5_first", 32'(gnt), 32'h1);
    for (int s = 0; s < SETTLE; s++) step();
    req = 4'b0000;
    step();

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, (1 << N) - 1));
      a_flat = $urandom();
      b_flat = $urandom();
      if (i == 150) begin
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        step();
        rst_n = 1'b1;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
